iq_power_feed: RTL and testbench

- Upstream feeder for the 32-bit windowed power accumulator.
- Takes signed 16-bit I/Q samples and computes the instantaneous power I²+Q² as a 32-bit unsigned value through a 3-stage pipeline.
- Drives the accumulator's data input (In_A), enable strobe (en) and 5-bit window-state input (state).
- Sequences integration windows (clear, run, drain, done) so that each window yields exactly WIN_LEN summed samples.

---
 rtl/iq_power_feed_pkg.sv | 18 +
 rtl/iq_sq_pipe.sv | 58 +++++
 rtl/iq_power_feed.sv | 113 +++++++++++
 tb/tb_iq_power_feed.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_power_feed_pkg.sv
// Shared types and constants for the I/Q power feeder.
// Imported by the top level and the squaring pipeline.
package iq_power_feed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fsm_e;

    localparam int CLEAR_CYCLES = 2;
    localparam int PIPE_LAT     = 3;
    localparam int STATE_W      = 5;
    localparam int SQ_W         = 32;

endpackage

// File: rtl/iq_sq_pipe.sv
// Three-stage I^2+Q^2 datapath: register, square, sum.
// A valid shift register tracks samples through the stages.
module iq_sq_pipe
    import iq_power_feed_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 v_i,
    input  logic signed [DW-1:0] i_i,
    input  logic signed [DW-1:0] q_i,
    output logic [SQ_W-1:0]      sq_o,
    output logic                 en_o
);

    logic [PIPE_LAT-1:0]     v_q;
    logic signed [DW-1:0]    i1_q;
    logic signed [DW-1:0]    q1_q;
    logic signed [SQ_W-1:0]  ie;
    logic signed [SQ_W-1:0]  qe;
    logic signed [SQ_W-1:0]  pi_q;
    logic signed [SQ_W-1:0]  pq_q;
    logic [SQ_W-1:0]         sq_q;
    logic [SQ_W-1:0]         sq_d;

    // Sign-extend before multiplying; each square is at most 2^30.
    assign ie = SQ_W'(i1_q);
    assign qe = SQ_W'(q1_q);

    assign sq_d = v_q[1] ? ($unsigned(pi_q) + $unsigned(pq_q)) : sq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            i1_q <= '0;
            q1_q <= '0;
            pi_q <= '0;
            pq_q <= '0;
            sq_q <= '0;
        end else begin
            v_q  <= {v_q[PIPE_LAT-2:0], v_i};
            sq_q <= sq_d;
            if (v_i) begin
                i1_q <= i_i;
                q1_q <= q_i;
            end
            if (v_q[0]) begin
                pi_q <= ie * ie;
                pq_q <= qe * qe;
            end
        end
    end

    assign sq_o = sq_q;
    assign en_o = v_q[PIPE_LAT-1];

endmodule

// File: rtl/iq_power_feed.sv
// Window sequencer and sample handshake feeding the power accumulator.
// Each window delivers exactly WIN_LEN squared samples.
module iq_power_feed
    import iq_power_feed_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int DW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic signed [DW-1:0] i_i,
    input  logic signed [DW-1:0] q_i,
    output logic [SQ_W-1:0]      sq_o,
    output logic                 sq_en_o,
    output logic [STATE_W-1:0]   state_o,
    output logic                 win_done_o,
    output logic                 busy_o
);

    localparam logic [STATE_W-1:0] WL    = STATE_W'(WIN_LEN);
    localparam logic [STATE_W-1:0] WL_P1 = STATE_W'(WIN_LEN + 1);
    localparam logic [STATE_W-1:0] ONE   = STATE_W'(1);
    localparam logic [1:0]         CL_LAST = 2'(CLEAR_CYCLES - 1);

    fsm_e               fsm_q;
    logic [STATE_W-1:0] in_cnt_q;
    logic [STATE_W-1:0] out_cnt_q;
    logic [STATE_W-1:0] out_cnt_d;
    logic [STATE_W-1:0] state_q;
    logic [1:0]         clr_q;
    logic               acc_d_q;
    logic               done_q;
    logic               accept;
    logic               sq_en;

    // A one-cycle gap after each accept lets the accumulator commit.
    assign in_ready_o = (fsm_q == ST_RUN) && (in_cnt_q < WL) && !acc_d_q;
    assign accept     = in_valid_i && in_ready_o;
    assign out_cnt_d  = out_cnt_q + (sq_en ? ONE : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= ST_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            state_q   <= '0;
            clr_q     <= '0;
            acc_d_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_d_q <= accept;
            done_q  <= 1'b0;
            if (accept) in_cnt_q <= in_cnt_q + ONE;
            if (sq_en) out_cnt_q <= out_cnt_d;
            unique case (fsm_q)
                ST_IDLE: begin
                    state_q <= '0;
                    clr_q   <= '0;
                    if (run_i) fsm_q <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    in_cnt_q  <= '0;
                    out_cnt_q <= '0;
                    acc_d_q   <= 1'b0;
                    state_q   <= '0;
                    if (clr_q == CL_LAST) begin
                        fsm_q   <= ST_RUN;
                        state_q <= ONE;
                    end else begin
                        clr_q <= clr_q + 2'd1;
                    end
                end
                ST_RUN: begin
                    state_q <= out_cnt_d + ONE;
                    if (in_cnt_q == WL) fsm_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    state_q <= out_cnt_d + ONE;
                    if (out_cnt_q == WL) begin
                        fsm_q   <= ST_DONE;
                        done_q  <= 1'b1;
                        state_q <= WL_P1;
                    end
                end
                ST_DONE: begin
                    state_q <= '0;
                    clr_q   <= '0;
                    fsm_q   <= run_i ? ST_CLEAR : ST_IDLE;
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    iq_sq_pipe #(.DW(DW)) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .v_i  (accept),
        .i_i  (i_i),
        .q_i  (q_i),
        .sq_o (sq_o),
        .en_o (sq_en)
    );

    assign sq_en_o    = sq_en;
    assign state_o    = state_q;
    assign win_done_o = done_q;
    assign busy_o     = (fsm_q != ST_IDLE);

endmodule

// File: tb/tb_iq_power_feed.sv
// Bench for iq_power_feed: window model plus directed vectors.
// Two instances cover WIN_LEN=16 and WIN_LEN=1.
module tb_iq_power_feed;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               a_run, a_valid, a_rdy, a_en, a_done, a_busy;
    logic signed [15:0] a_i, a_q;
    logic [31:0]        a_sq;
    logic [4:0]         a_state;

    logic               b_run, b_valid, b_rdy, b_en, b_done, b_busy;
    logic signed [15:0] b_i, b_q;
    logic [31:0]        b_sq;
    logic [4:0]         b_state;

    iq_power_feed #(.WIN_LEN(16), .DW(16)) dut_a (
        .clk(clk), .rst(rst), .run_i(a_run),
        .in_valid_i(a_valid), .in_ready_o(a_rdy),
        .i_i(a_i), .q_i(a_q), .sq_o(a_sq), .sq_en_o(a_en),
        .state_o(a_state), .win_done_o(a_done), .busy_o(a_busy)
    );

    iq_power_feed #(.WIN_LEN(1), .DW(16)) dut_b (
        .clk(clk), .rst(rst), .run_i(b_run),
        .in_valid_i(b_valid), .in_ready_o(b_rdy),
        .i_i(b_i), .q_i(b_q), .sq_o(b_sq), .sq_en_o(b_en),
        .state_o(b_state), .win_done_o(b_done), .busy_o(b_busy)
    );

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [31:0] sq_of(input logic signed [15:0] i,
                                          input logic signed [15:0] q);
        longint x = i;
        longint y = q;
        return 32'(x * x + y * y);
    endfunction

    function automatic logic [31:0] pat(input int mode, input int k);
        logic [15:0] x, y;
        if (mode == 1) return {16'd1, 16'd1};
        case (k)
            0: begin x = 16'd3;      y = 16'd4;      end
            1: begin x = 16'h8000;   y = 16'h8000;   end
            2: begin x = 16'h7fff;   y = 16'd0;      end
            3: begin x = 16'hffff;   y = 16'hffff;   end
            default: begin
                x = 16'(k * 2311 - 17000);
                y = 16'(9000 - k * 1234);
            end
        endcase
        return {x, y};
    endfunction

    // Behavioural model of dut_a: expected outputs queued by due cycle,
    // plus the downstream accumulator the feeder drives.
    typedef struct {
        int          due;
        logic [31:0] v;
    } exp_t;

    exp_t        expq[$];
    exp_t        e;
    logic [31:0] got[$];
    bit          mon_en   = 0;
    bit          rdy_prev = 0;
    int          en_cnt   = 0;
    int          win_in   = 0;
    int          last_en  = -100;
    int          last_done = -100;
    longint      win_exp  = 0;
    longint      acc_m    = 0;
    longint      done_sum = 0;
    logic [4:0]  st_r     = '0;

    always @(negedge clk) if (mon_en) begin
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("sq_en", a_en, 1);
            chk("sq_o", a_sq, expq[0].v);
            void'(expq.pop_front());
            en_cnt++;
            last_en = cyc;
        end else begin
            chk("sq_en_idle", a_en, 0);
        end
        if (a_en) got.push_back(a_sq);
        if (rdy_prev) chk("rdy_gap", a_rdy, 0);
        rdy_prev = a_valid && a_rdy;
        if (a_valid && a_rdy) begin
            e.due = cyc + 3;
            e.v   = sq_of(a_i, a_q);
            expq.push_back(e);
            win_exp += e.v;
            win_in++;
            chk("win_in_bound", win_in <= 16, 1);
        end
        if (a_done) begin
            chk("done_lat", cyc - last_en, 2);
            chk("done_cnt", en_cnt, 16);
            chk("done_sum", acc_m, win_exp);
            chk("done_state", a_state, 17);
            done_sum  = acc_m;
            last_done = cyc;
            en_cnt    = 0;
            win_exp   = 0;
            win_in    = 0;
        end else if (cyc == last_done + 1) begin
            chk("state_clear", a_state, 0);
        end
        if (rst) begin
            while (expq.size() > 0 && expq[expq.size()-1].due > cyc)
                void'(expq.pop_back());
            en_cnt   = 0;
            win_exp  = 0;
            win_in   = 0;
            rdy_prev = 0;
        end
        if (st_r == 0) acc_m = 0;
        else if (a_en) acc_m += a_sq;
        st_r = a_state;
    end

    task automatic stream(input int n, input int mode, input int drop_at);
        int prev = 0;
        bit ok;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            {a_i, a_q} = pat(mode, k);
            a_valid = 1'b1;
            ok = 0;
            for (int w = 0; w < 100; w++) begin
                @(negedge clk);
                if (a_rdy) begin ok = 1; break; end
            end
            if (!ok) begin
                fail("accept_wait");
                a_valid = 1'b0;
                return;
            end
            if (k > 0) chk("rdy_period", cyc - prev, 2);
            prev = cyc;
            @(posedge clk); #1;
            if (k + 1 == drop_at) a_run = 1'b0;
        end
        a_valid = 1'b0;
    endtask

    task automatic wait_a_done();
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            if (a_done) return;
        end
        fail("done_wait");
    endtask

    task automatic count_zeros();
        int z = 0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (a_state == 0) z++;
            else break;
        end
        chk("clear_gap", z, 2);
    endtask

    task automatic chk_idle_a(input string nm);
        chk({nm, "_rdy"}, a_rdy, 0);
        chk({nm, "_sq"}, a_sq, 0);
        chk({nm, "_en"}, a_en, 0);
        chk({nm, "_state"}, a_state, 0);
        chk({nm, "_done"}, a_done, 0);
        chk({nm, "_busy"}, a_busy, 0);
    endtask

    initial begin
        int  ta, te;
        bit  ok;
        rst = 1'b1;
        a_run = 0; a_valid = 0; a_i = 0; a_q = 0;
        b_run = 0; b_valid = 0; b_i = 0; b_q = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_a("reset");
        chk("reset_b_state", b_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1;

        // WIN_LEN=1, single sample (3,4)
        b_run = 1; b_valid = 1; b_i = 3; b_q = 4;
        ok = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (b_rdy) begin ok = 1; break; end
        end
        if (!ok) fail("b_accept");
        ta = cyc;
        @(posedge clk); #1;
        b_valid = 0; b_run = 0;
        ok = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (b_en) begin ok = 1; break; end
        end
        if (!ok) fail("b_sq_en");
        te = cyc;
        chk("b_lat", te - ta, 3);
        chk("b_sq", b_sq, 25);
        ok = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (b_done) begin ok = 1; break; end
        end
        if (!ok) fail("b_done");
        chk("b_done_lat", cyc - te, 2);
        chk("b_done_state", b_state, 2);
        @(negedge clk);
        chk("b_state_after", b_state, 0);
        chk("b_busy_after", b_busy, 0);
        chk("b_sq_hold", b_sq, 25);

        // Window A: corner samples, valid held high, run held
        got.delete();
        a_run = 1;
        stream(16, 0, 0);
        wait_a_done();
        #1;
        chk("A_count", got.size(), 16);
        chk("A_sq0", got[0], 32'd25);
        chk("A_sq1", got[1], 32'h8000_0000);
        chk("A_sq2", got[2], 32'h3FFF_0001);
        chk("A_sq3", got[3], 32'd2);
        count_zeros();

        // Window B: all (1,1), run held
        stream(16, 1, 0);
        wait_a_done();
        #1;
        chk("B_sum", done_sum, 32);
        count_zeros();

        // Window C: run dropped after 5th sample
        stream(16, 1, 5);
        wait_a_done();
        #1;
        chk("C_sum", done_sum, 32);
        @(negedge clk);
        chk("C_busy", a_busy, 0);
        chk("C_state", a_state, 0);

        // Reset one cycle after the 7th accepted sample
        @(posedge clk); #1;
        a_run = 1;
        stream(7, 1, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sq", a_sq, 0);
        chk("rst_en", a_en, 0);
        chk("rst_state", a_state, 0);
        chk("rst_done", a_done, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rdy", a_rdy, 0);
        repeat (6) @(negedge clk);
        chk("rst_idle", a_busy, 0);

        // Restart gives a clean window
        @(posedge clk); #1;
        a_run = 1;
        stream(16, 1, 1);
        wait_a_done();
        #1;
        chk("R_sum", done_sum, 32);
        @(negedge clk);
        chk("R_busy", a_busy, 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
